// File: rtl/watch_pkg.sv
// Shared encodings for the watch time-set path: set-mode states and the
// field-select values driven towards the hour/min/sec counters.
package watch_pkg;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_HOUR = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_SEC  = 2'd2;

  // NORMAL reports the hour field so o_sel is 0 outside set mode.
  function automatic logic [1:0] state_sel(input state_t s);
    case (s)
      SET_MIN: return SEL_MIN;
      SET_SEC: return SEL_SEC;
      default: return SEL_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level. prev resets to 0 so a
// button held through reset release still produces a single edge.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-set controller: mode/up/down buttons drive the set-mode FSM, field
// select, inc/dec pulses with press-and-hold auto-repeat, idle timeout and blink.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int BLINK_HALF     = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_set_mode,
  output logic [1:0] o_sel,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_blink
);

  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int IDLE_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BLINK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);

  logic mode_rise, up_rise, down_rise;

  btn_edge u_mode_edge (.clk(clk), .reset(reset), .level(i_btn_mode), .rise(mode_rise));
  btn_edge u_up_edge   (.clk(clk), .reset(reset), .level(i_btn_up),   .rise(up_rise));
  btn_edge u_down_edge (.clk(clk), .reset(reset), .level(i_btn_down), .rise(down_rise));

  state_t               state, state_n;
  logic [HOLD_W-1:0]    hold_cnt, hold_cnt_n;
  logic                 repeat_ph, repeat_ph_n;
  logic [IDLE_W-1:0]    idle_cnt, idle_cnt_n;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_n;
  logic                 blink_n, inc_n, dec_n;
  logic                 timeout, change, active, run;

  always_comb begin
    state_n     = state;
    hold_cnt_n  = '0;
    repeat_ph_n = 1'b0;
    idle_cnt_n  = '0;
    blink_cnt_n = '0;
    blink_n     = 1'b1;
    inc_n       = 1'b0;
    dec_n       = 1'b0;

    // Timeout is checked first so it overrides a coincident mode edge.
    timeout = (state != NORMAL) && (idle_cnt == IDLE_LAST);
    if (timeout)        state_n = NORMAL;
    else if (mode_rise) state_n = state_t'(state + 2'd1);

    change = (state_n != state);
    active = (state != NORMAL) && !change;

    if (active && (up_rise ^ down_rise)) begin
      inc_n = up_rise;
      dec_n = down_rise;
    end

    // Hold counter only advances for a single steady button; any edge restarts it.
    run = active && (i_btn_up ^ i_btn_down) && !(up_rise | down_rise);
    if (run) begin
      if (hold_cnt == (repeat_ph ? REPEAT_LAST : HOLD_LAST)) begin
        repeat_ph_n = 1'b1;
        inc_n       = i_btn_up;
        dec_n       = i_btn_down;
      end else begin
        hold_cnt_n  = hold_cnt + HOLD_W'(1);
        repeat_ph_n = repeat_ph;
      end
    end

    if (!(state_n == NORMAL || change || mode_rise || up_rise || down_rise))
      idle_cnt_n = idle_cnt + IDLE_W'(1);

    // A pulse restarts blink at 1 so the edited field is visible right away.
    if (!(state_n == NORMAL || change || inc_n || dec_n)) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_n = ~o_blink;
      end else begin
        blink_cnt_n = blink_cnt + BLINK_W'(1);
        blink_n     = o_blink;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      hold_cnt   <= '0;
      repeat_ph  <= 1'b0;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
      o_set_mode <= 1'b0;
      o_sel      <= SEL_HOUR;
      o_inc      <= 1'b0;
      o_dec      <= 1'b0;
      o_blink    <= 1'b1;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      repeat_ph  <= repeat_ph_n;
      idle_cnt   <= idle_cnt_n;
      blink_cnt  <= blink_cnt_n;
      o_set_mode <= (state_n != NORMAL);
      o_sel      <= state_sel(state_n);
      o_inc      <= inc_n;
      o_dec      <= dec_n;
      o_blink    <= blink_n;
    end
  end

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed vector table, hand sequences for hold,
// timeout and reset, then random button traffic against a behavioural model.
module tb_watch_set_ctrl;

  localparam int HOLD    = 8;
  localparam int REPEAT  = 4;
  localparam int TIMEOUT = 40;
  localparam int BHALF   = 3;
  localparam logic [5:0] RST_VEC = 6'b000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down;
  logic       o_set_mode, o_inc, o_dec, o_blink;
  logic [1:0] o_sel;
  logic [5:0] dut_vec;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  // Behavioural model: ages in cycles rather than saturating counters.
  int   m_state, m_hold, m_idle, m_blink;
  logic m_pm, m_pu, m_pd;

  typedef struct packed {
    logic       m;
    logic       u;
    logic       d;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[31];

  watch_set_ctrl #(
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT),
    .TIMEOUT_CYCLES(TIMEOUT), .BLINK_HALF(BHALF)
  ) dut (
    .clk(clk), .reset(reset),
    .i_btn_mode(btn_mode), .i_btn_up(btn_up), .i_btn_down(btn_down),
    .o_set_mode(o_set_mode), .o_sel(o_sel), .o_inc(o_inc), .o_dec(o_dec),
    .o_blink(o_blink)
  );

  assign dut_vec = {o_set_mode, o_sel, o_inc, o_dec, o_blink};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_hold = 0; m_idle = 0; m_blink = 0;
    m_pm = 1'b0; m_pu = 1'b0; m_pd = 1'b0;
  endtask

  task automatic model_edge(input logic m, input logic u, input logic d);
    logic em, eu, ed, in_set, change, pi, pd, run, bl;
    int   ns;
    em = m & ~m_pm; eu = u & ~m_pu; ed = d & ~m_pd;
    in_set = (m_state != 0);
    ns = m_state;
    if (in_set && m_idle == TIMEOUT - 1) ns = 0;
    else if (em)                         ns = (m_state + 1) % 4;
    change = (ns != m_state);
    pi = 1'b0; pd = 1'b0;
    if (in_set && !change && (eu != ed)) begin pi = eu; pd = ed; end
    run = in_set && !change && (u != d) && !eu && !ed;
    if (run) begin
      m_hold++;
      if (m_hold == HOLD || (m_hold > HOLD && (m_hold - HOLD) % REPEAT == 0)) begin
        pi = u; pd = d;
      end
    end else begin
      m_hold = 0;
    end
    if (ns == 0 || change || em || eu || ed) m_idle = 0;
    else                                     m_idle++;
    if (ns == 0 || change || pi || pd) m_blink = 0;
    else                               m_blink++;
    bl = (ns == 0) ? 1'b1 : (((m_blink / BHALF) % 2) == 0);
    exp_q.push_back({ns != 0, (ns == 0) ? 2'd0 : 2'(ns - 1), pi, pd, bl});
    m_state = ns; m_pm = m; m_pu = u; m_pd = d;
  endtask

  // Scoreboard: every clock out of reset is predicted and compared.
  always @(posedge clk) begin
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_edge(btn_mode, btn_up, btn_down);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL model_queue: got empty queue expected one entry");
      end else begin
        check("model", dut_vec, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic m, input logic u, input logic d);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int exit_n;
    logic exp_b, exp_d;
    logic lm, lu, ld;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b100001};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 6'b100001};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 6'b100001};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'b100000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 6'b101001};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 6'b101001};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 6'b101001};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 6'b101000};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 6'b101000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 6'b110001};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 6'b110001};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 6'b110001};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 6'b110000};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 6'b110000};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 6'b000001};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 6'b000001};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 6'b000001};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 6'b100001};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 6'b100001};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 6'b101001};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 6'b101001};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 6'b101101};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 6'b101001};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 6'b101001};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 6'b101000};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 6'b101000};
    tbl[27] = '{1'b0, 1'b1, 1'b1, 6'b101000};
    tbl[28] = '{1'b0, 1'b0, 1'b0, 6'b101001};
    tbl[29] = '{1'b1, 1'b1, 1'b0, 6'b110001};
    tbl[30] = '{1'b0, 1'b0, 1'b0, 6'b110001};

    // Clock/reset
    reset = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", dut_vec, RST_VEC);
    reset = 1'b0;

    // Mode cycling, up in NORMAL, single up pulse, up+down, mode+up
    for (int i = 0; i < 31; i++) begin
      step(tbl[i].m, tbl[i].u, tbl[i].d);
      check($sformatf("table_row%0d", i), dut_vec, tbl[i].exp);
    end

    // Idle in SET_SEC (entered at table row 29): timeout and blink
    exit_n = -1;
    for (int n = 1; n <= 60; n++) begin
      step(1'b0, 1'b0, 1'b0);
      if (!o_set_mode) begin
        exit_n = n;
        check("timeout_exit_blink", {o_sel, o_blink}, 6'b000001);
        break;
      end
      exp_b = (((n + 1) / BHALF) % 2) == 0;
      check("timeout_blink", {5'b0, o_blink}, {5'b0, exp_b});
    end
    n_checks++;
    if (exit_n != TIMEOUT - 1) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d expected %0d", exit_n, TIMEOUT - 1);
    end

    // Hold down in SET_HOUR for 20 cycles
    step(1'b1, 1'b0, 1'b0);
    for (int o = 1; o <= 26; o++) begin
      step(1'b0, 1'b0, (o <= 20));
      exp_d = (o == 1) || (o == 9) || (o == 13) || (o == 17);
      check($sformatf("hold_dec_k%0d", o), {5'b0, o_dec}, {5'b0, exp_d});
      check($sformatf("hold_inc_k%0d", o), {5'b0, o_inc}, 6'b0);
    end

    // Reset asserted mid up-hold in SET_MIN
    step(1'b1, 1'b0, 1'b0);
    for (int o = 0; o < 12; o++) step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_async", dut_vec, RST_VEC);
    @(negedge clk);
    check("reset_hold", dut_vec, RST_VEC);
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    check("post_reset_up_normal", dut_vec, RST_VEC);
    step(1'b0, 1'b0, 1'b0);

    // Random button traffic, checked by the scoreboard
    lm = 1'b0; lu = 1'b0; ld = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lm = ~lm;
      if ($urandom_range(0, 9) == 0)  lu = ~lu;
      if ($urandom_range(0, 9) == 0)  ld = ~ld;
      step(lm, lu, ld);
    end
    step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
